// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access sequencer: load/store size
// codes, FSM state encoding and request classification helpers.
package mem_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

  // Stores have no unsigned variants; loads accept B/H/W/BU/HU.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f);
    if (we) return (f == LS_B) || (f == LS_H) || (f == LS_W);
    return (f == LS_B) || (f == LS_H) || (f == LS_W) || (f == LS_BU) || (f == LS_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    return (((f == LS_H) || (f == LS_HU)) && a[0]) || ((f == LS_W) && (a != 2'b00));
  endfunction

  // Byte offset after forcing halfwords/words onto their natural boundary.
  function automatic logic [1:0] natural_off(input logic [2:0] f, input logic [1:0] a);
    case (f)
      LS_H, LS_HU: return {a[1], 1'b0};
      LS_W:        return 2'b00;
      default:     return a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load right-shift with sign or zero extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  store_funct3,
  input  logic [1:0]  store_off,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_off,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be    = 4'hF;
    wdata = store_data;
    case (store_funct3)
      LS_B: begin
        be    = 4'b0001 << store_off;
        wdata = {4{store_data[7:0]}};
      end
      LS_H: begin
        be    = 4'b0011 << {store_off[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = store_data;
      end
    endcase
  end

  assign shifted = load_word >> {load_off, 3'b000};

  always_comb begin
    load_data = shifted;
    case (load_funct3)
      LS_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      LS_BU:   load_data = {24'h0, shifted[7:0]};
      LS_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      LS_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns a single-cycle load/store request into a dmem req/gnt/rvalid transaction,
// stalling the pipeline until done. Define MEM_MISALIGN_TRAP_EN to abort
// misaligned H/W accesses with an error instead of forcing natural alignment.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
  logic             lat_we;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_off;
  logic [1:0]       req_off;
  logic             trap;
  logic [3:0]       st_be;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

`ifdef MEM_MISALIGN_TRAP_EN
  assign req_off = req_addr[1:0];
  assign trap    = ~funct3_legal(req_we, req_funct3) | misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_off = natural_off(req_funct3, req_addr[1:0]);
  assign trap    = ~funct3_legal(req_we, req_funct3);
`endif

  assign cnt_inc = cnt + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Combinational so the requesting instruction is held in its first cycle.
  assign stall = ~rst & (((state == IDLE) & req_valid) | (state == REQ) | (state == WAIT));

  lsu_align u_align (
    .store_funct3 (req_funct3),
    .store_off    (req_off),
    .store_data   (req_wdata),
    .be           (st_be),
    .wdata        (st_wdata),
    .load_funct3  (lat_funct3),
    .load_off     (lat_off),
    .load_word    (dmem_rdata),
    .load_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_off    <= req_off;
            if (trap) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state      <= REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= req_we;
              dmem_addr  <= {req_addr[31:2], 2'b00};
              dmem_be    <= st_be;
              dmem_wdata <= st_wdata;
            end
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          if (dmem_gnt && lat_we) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            rsp_valid <= 1'b1;
          end else if (timeout) begin
            state     <= DONE;
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (dmem_gnt) begin
            state    <= WAIT;
            dmem_req <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt_inc;
          // A response on the final budgeted cycle still completes normally.
          if (dmem_rvalid) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
          end else if (timeout) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
